// File: rtl/plic_gateway.sv
// Interrupt gateway between raw source lines and the PLIC core.
// Each source has a synchronizer, a single-bit edge deferral and an IDLE/PENDING/IN_SERVICE tracker.
module plic_gateway #(
  parameter int irqmax = 73
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic [irqmax-1:0] i_irq,
  input  logic [irqmax-1:0] i_edge_mode,
  input  logic              i_claim_valid,
  input  logic [9:0]        i_claim_id,
  input  logic              i_complete_valid,
  input  logic [9:0]        i_complete_id,
  output logic [irqmax-1:0] o_pending,
  output logic [irqmax-1:0] o_in_service
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PENDING    = 2'd1,
    ST_IN_SERVICE = 2'd2
  } state_e;

  // Source 0 is hardwired off; its input bits are deliberately dropped.
  logic w_unused;
  assign w_unused = &{1'b0, i_irq[0], i_edge_mode[0]};

  assign o_pending[0]    = 1'b0;
  assign o_in_service[0] = 1'b0;

  logic [irqmax-1:1] r_s1, r_s2, r_s3;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= i_irq[irqmax-1:1];
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  for (genvar k = 1; k < irqmax; k++) begin : g_src
    localparam logic [9:0] SRC_ID = 10'(k);

    state_e r_state, w_state_nxt;
    logic   r_deferred, w_deferred_nxt;
    logic   r_pend, r_insvc;
    logic   w_rise, w_request, w_claim_hit, w_complete_hit;

    assign w_rise         = r_s2[k] & ~r_s3[k];
    assign w_request      = i_edge_mode[k] ? (w_rise | r_deferred) : r_s2[k];
    assign w_claim_hit    = i_claim_valid & (i_claim_id == SRC_ID);
    assign w_complete_hit = i_complete_valid & (i_complete_id == SRC_ID);

    always_comb begin
      w_state_nxt    = r_state;
      w_deferred_nxt = r_deferred;
      case (r_state)
        ST_IDLE: begin
          if (w_request) begin
            w_state_nxt    = ST_PENDING;
            w_deferred_nxt = 1'b0;
          end
        end
        ST_PENDING: begin
          // A rise while merely pending merges; only one racing the claim is remembered.
          if (w_claim_hit) begin
            w_state_nxt    = ST_IN_SERVICE;
            w_deferred_nxt = r_deferred | w_rise;
          end
        end
        ST_IN_SERVICE: begin
          if (w_complete_hit) begin
            w_state_nxt    = w_request ? ST_PENDING : ST_IDLE;
            w_deferred_nxt = 1'b0;
          end else begin
            w_deferred_nxt = r_deferred | w_rise;
          end
        end
        default: begin
          w_state_nxt    = ST_IDLE;
          w_deferred_nxt = 1'b0;
        end
      endcase
      if (!i_edge_mode[k]) w_deferred_nxt = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
        r_state    <= ST_IDLE;
        r_deferred <= 1'b0;
        r_pend     <= 1'b0;
        r_insvc    <= 1'b0;
      end else begin
        r_state    <= w_state_nxt;
        r_deferred <= w_deferred_nxt;
        r_pend     <= (r_state == ST_PENDING);
        r_insvc    <= (r_state == ST_IN_SERVICE);
      end
    end

    assign o_pending[k]    = r_pend;
    assign o_in_service[k] = r_insvc;
  end

endmodule

// File: tb/tb_plic_gateway.sv
// Self-checking bench for plic_gateway: directed scenarios with literal expectations
// plus a randomized phase compared every cycle against a behavioural model.
module tb_plic_gateway;
  localparam int IRQ = 73;

  logic           clk = 1'b0;
  logic           nrst = 1'b0;
  logic [IRQ-1:0] irq = '0;
  logic [IRQ-1:0] edge_mode = '0;
  logic           claim_valid = 1'b0;
  logic [9:0]     claim_id = '0;
  logic           complete_valid = 1'b0;
  logic [9:0]     complete_id = '0;
  logic [IRQ-1:0] pending, in_service;

  int checks = 0;
  int errors = 0;

  plic_gateway #(.irqmax(IRQ)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_irq(irq), .i_edge_mode(edge_mode),
    .i_claim_valid(claim_valid), .i_claim_id(claim_id),
    .i_complete_valid(complete_valid), .i_complete_id(complete_id),
    .o_pending(pending), .o_in_service(in_service)
  );

  always #5 clk = ~clk;

  // Behavioural model: 0 = idle, 1 = pending, 2 = in service.
  int             ms [IRQ];
  bit             mdef [IRQ];
  bit [IRQ-1:0]   m_s1 = '0, m_s2 = '0, m_s3 = '0;
  bit [IRQ-1:0]   exp_pend = '0, exp_insvc = '0;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int k = 0; k < IRQ; k++) begin ms[k] = 0; mdef[k] = 1'b0; end
      m_s1 = '0; m_s2 = '0; m_s3 = '0;
      exp_pend = '0; exp_insvc = '0;
    end else begin
      for (int k = 1; k < IRQ; k++) begin
        bit rise, req, ch, cp;
        rise = m_s2[k] && !m_s3[k];
        req  = edge_mode[k] ? (rise || mdef[k]) : m_s2[k];
        ch   = claim_valid && (int'(claim_id) == k);
        cp   = complete_valid && (int'(complete_id) == k);
        exp_pend[k]  = (ms[k] == 1);
        exp_insvc[k] = (ms[k] == 2);
        if (ms[k] == 0) begin
          if (req) begin ms[k] = 1; mdef[k] = 1'b0; end
        end else if (ms[k] == 1) begin
          if (ch) begin ms[k] = 2; if (rise) mdef[k] = 1'b1; end
        end else begin
          if (cp) begin ms[k] = req ? 1 : 0; mdef[k] = 1'b0; end
          else if (rise) mdef[k] = 1'b1;
        end
        if (!edge_mode[k]) mdef[k] = 1'b0;
      end
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = irq;
    end
  end

  always @(negedge clk) begin
    checks++;
    if (pending !== exp_pend) begin
      errors++;
      $display("FAIL model_pending t=%0t: got %h expected %h", $time, pending, exp_pend);
    end
    checks++;
    if (in_service !== exp_insvc) begin
      errors++;
      $display("FAIL model_in_service t=%0t: got %h expected %h", $time, in_service, exp_insvc);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [IRQ-1:0] act, input logic [IRQ-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic do_claim(input int id);
    claim_valid = 1'b1; claim_id = 10'(id);
    step(1);
    claim_valid = 1'b0; claim_id = '0;
    step(1);
  endtask

  task automatic do_complete(input int id);
    complete_valid = 1'b1; complete_id = 10'(id);
    step(1);
    complete_valid = 1'b0; complete_id = '0;
    step(1);
  endtask

  task automatic pulse(input int id);
    irq[id] = 1'b1;
    step(1);
    irq[id] = 1'b0;
  endtask

  logic [IRQ-1:0] one = 1;

  initial begin
    step(3);
    chk("reset_pending", pending, '0);
    chk("reset_in_service", in_service, '0);
    nrst = 1'b1;
    step(2);

    // Level source 5: latency, claim, re-pend after completion while still high.
    irq[5] = 1'b1;
    step(3);
    chk1("lvl5_not_yet_edge3", pending[5], 1'b0);
    step(1);
    chk1("lvl5_pending_edge4", pending[5], 1'b1);
    do_claim(5);
    chk1("lvl5_in_service", in_service[5], 1'b1);
    chk1("lvl5_pending_cleared", pending[5], 1'b0);
    do_complete(5);
    chk1("lvl5_repend", pending[5], 1'b1);
    chk1("lvl5_insvc_cleared", in_service[5], 1'b0);
    irq[5] = 1'b0;
    step(4);
    do_claim(5);
    do_complete(5);
    chk("lvl5_idle_pend", pending, '0);
    chk("lvl5_idle_insvc", in_service, '0);

    // Edge source 7: two pulses during service collapse into one deferred request.
    edge_mode[7] = 1'b1;
    pulse(7);
    step(3);
    chk1("edg7_pending", pending[7], 1'b1);
    do_claim(7);
    chk1("edg7_in_service", in_service[7], 1'b1);
    pulse(7); step(3);
    pulse(7); step(5);
    chk1("edg7_still_insvc", in_service[7], 1'b1);
    chk1("edg7_no_pending", pending[7], 1'b0);
    do_complete(7);
    chk1("edg7_deferred_pend", pending[7], 1'b1);
    do_claim(7);
    do_complete(7);
    step(4);
    chk("edg7_idle_pend", pending, '0);
    chk("edg7_idle_insvc", in_service, '0);

    // Invalid claims with src 4 pending as background.
    irq[4] = 1'b1;
    step(5);
    do_claim(0);
    chk("claim0_pend", pending, one << 4);
    do_claim(73);
    chk("claim73_pend", pending, one << 4);
    do_claim(3);
    chk("claim3_pend", pending, one << 4);
    chk("claim3_insvc", in_service, '0);

    // Same-cycle claim of 2 and complete of 9.
    edge_mode[9] = 1'b1;
    pulse(9);
    irq[2] = 1'b1;
    step(5);
    do_claim(9);
    chk1("sim_9_insvc_pre", in_service[9], 1'b1);
    chk1("sim_2_pend_pre", pending[2], 1'b1);
    claim_valid = 1'b1; claim_id = 10'd2;
    complete_valid = 1'b1; complete_id = 10'd9;
    step(1);
    claim_valid = 1'b0; complete_valid = 1'b0;
    claim_id = '0; complete_id = '0;
    step(1);
    chk1("sim_2_insvc", in_service[2], 1'b1);
    chk1("sim_9_insvc", in_service[9], 1'b0);
    chk1("sim_9_pend", pending[9], 1'b0);

    // Reset during service of edge source 72 held high.
    edge_mode[72] = 1'b1;
    irq[72] = 1'b1;
    step(4);
    chk1("src72_pending", pending[72], 1'b1);
    do_claim(72);
    chk1("src72_insvc", in_service[72], 1'b1);
    nrst = 1'b0;
    #1;
    chk("rst_async_pend", pending, '0);
    chk("rst_async_insvc", in_service, '0);
    step(2);
    nrst = 1'b1;
    step(3);
    chk1("src72_post_rst_edge3", pending[72], 1'b0);
    step(1);
    chk1("src72_post_rst_edge4", pending[72], 1'b1);

    // Randomized phase.
    for (int c = 0; c < 4000; c++) begin
      int q_p[$];
      int q_s[$];
      for (int k = 1; k < IRQ; k++) begin
        if (ms[k] == 1) q_p.push_back(k);
        if (ms[k] == 2) q_s.push_back(k);
      end
      if ($urandom_range(0, 2) == 0) begin
        int idx;
        idx = $urandom_range(0, IRQ - 1);
        irq[idx] = ~irq[idx];
      end
      if ($urandom_range(0, 49) == 0) begin
        int idx;
        idx = $urandom_range(0, IRQ - 1);
        edge_mode[idx] = ~edge_mode[idx];
      end
      claim_valid = ($urandom_range(0, 2) == 0);
      if (q_p.size() > 0 && $urandom_range(0, 9) < 7)
        claim_id = 10'(q_p[$urandom_range(0, q_p.size() - 1)]);
      else
        claim_id = 10'($urandom_range(0, 1023));
      complete_valid = ($urandom_range(0, 2) == 0);
      if (q_s.size() > 0 && $urandom_range(0, 9) < 7)
        complete_id = 10'(q_s[$urandom_range(0, q_s.size() - 1)]);
      else
        complete_id = 10'($urandom_range(0, 80));
      if (c == 2000) nrst = 1'b0;
      if (c == 2003) nrst = 1'b1;
      step(1);
    end
    claim_valid = 1'b0;
    complete_valid = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/plic_gateway.md
PLIC_GATEWAY -- requirements
Module: plic_gateway

Interface
REQ-001 SHALL have parameter: irqmax, 73, number of interrupt sources including hardwired source 0 (2..1024).
REQ-002 SHALL have port: i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: i_nrst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: i_irq  input  irqmax  raw interrupt lines, asynchronous to i_clk.
REQ-005 SHALL have port: i_edge_mode  input  irqmax  per-source trigger type (1 = rising edge, 0 = level-high).
REQ-006 SHALL have port: i_claim_valid  input  1  claim strobe from the PLIC core, one cycle per claim.
REQ-007 SHALL have port: i_claim_id  input  10  source ID being claimed.
REQ-008 SHALL have port: i_complete_valid  input  1  completion strobe from the PLIC core.
REQ-009 SHALL have port: i_complete_id  input  10  source ID being completed.
REQ-010 SHALL have port: o_pending  output  irqmax  registered per-source pending vector to the PLIC core.
REQ-011 SHALL have port: o_in_service  output  irqmax  registered per-source claimed-not-completed vector.

Function
REQ-012 SHALL pass each i_irq bit through a two-flop synchronizer (s1, s2) plus one history flop (s3).
REQ-013 SHALL define rise[k] = s2[k] & ~s3[k]; request[k] = i_edge_mode[k] ? (rise[k] | deferred[k]) : s2[k].
REQ-014 SHALL hold per source k (1..irqmax-1) a 2-bit state: IDLE, PENDING, IN_SERVICE.
REQ-015 SHALL move IDLE -> PENDING when request[k] = 1; otherwise remain IDLE.
REQ-016 SHALL move PENDING -> IN_SERVICE when i_claim_valid = 1 and i_claim_id = k.
REQ-017 SHALL move IN_SERVICE -> PENDING on i_complete_valid with i_complete_id = k if request[k] = 1 that cycle, else -> IDLE.
REQ-018 SHALL treat a claim for a source not in PENDING, or a complete for a source not in IN_SERVICE, as a no-op.
REQ-019 SHALL ignore claim/complete IDs equal to 0 or >= irqmax.
REQ-020 SHALL apply a simultaneous claim and complete in the same cycle independently; both take effect when they target different sources.
REQ-021 SHALL set deferred[k] on rise[k] while state is PENDING-to-IN_SERVICE transitioning or IN_SERVICE; single bit, further edges while set are lost.
REQ-022 SHALL merge a rise[k] while in PENDING (no deferred set, no second pending).
REQ-023 SHALL clear deferred[k] when state leaves IN_SERVICE, when IDLE -> PENDING consumes it, or whenever i_edge_mode[k] = 0.
REQ-024 SHALL drive o_pending[k] = (state == PENDING) and o_in_service[k] = (state == IN_SERVICE) from registers, no combinational path from inputs.
REQ-025 SHALL tie bit 0 of o_pending and o_in_service to 0; source 0 has no state.
REQ-026 SHALL assert o_pending[k] at the 4th rising edge of i_clk after i_irq[k] rises (setup met): s1, s2, state, visible.
REQ-027 SHALL make level sources that remain high after completion re-pend on the cycle after complete (via REQ-017), with no IDLE cycle.

Reset
REQ-028 SHALL, while i_nrst = 0, asynchronously clear s1, s2, s3, deferred, and set every state to IDLE; o_pending = 0, o_in_service = 0.
REQ-029 SHALL discard any in-flight claim or interrupt at reset assertion; after deassertion, a line already high is seen as a rise (s3 = 0) in edge mode.

Verification
REQ-030 SHALL cover: level src 5 high, claim id 5, complete id 5 with line still high -> pending[5] at edge 4, in_service[5] after claim, pending[5] re-asserts 1 cycle after complete.
REQ-031 SHALL cover: edge src 7 pulsed twice during IN_SERVICE -> one deferred; complete id 7 -> pending[7] = 1 once; next claim/complete -> IDLE.
REQ-032 SHALL cover: claim id 0, id 73, id 3 while src 3 IDLE -> all vectors unchanged.
REQ-033 SHALL cover: same-cycle claim id 2 (PENDING) and complete id 9 (IN_SERVICE, line low) -> in_service[2] = 1, in_service[9] = 0, pending[9] = 0.
REQ-034 SHALL cover: i_nrst low mid-service of src 72 with i_irq[72] held high in edge mode -> all outputs 0 immediately; after release pending[72] = 1 at edge 4.
